// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: oversampled SPI slave, any CPOL/CPHA mode,
// configurable word width and bit order, FWFT RX/TX FIFOs.

module spi_slave_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rp];

    // storage array, contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

module spi_slave_fifo #(
    parameter int   WIDTH     = 8,
    parameter int   DEPTH     = 4,
    parameter logic CPOL      = 1'b0,
    parameter logic CPHA      = 1'b0,
    parameter logic MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             SCK,
    input  logic             nCS,
    input  logic             MOSI,
    output logic             MISO,
    output logic             MISO_OE,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             overrun,
    output logic             underrun
);
    localparam int CW = $clog2(WIDTH);

    logic             sck_s1, sck_s2, sck_s3;
    logic             ncs_s1, ncs_s2, ncs_s3;
    logic             mosi_s1, mosi_s2;
    logic             lead, trail, samp, shft;
    logic             ncs_fall, ncs_rise;
    logic [CW-1:0]    count;
    logic [WIDTH-2:0] rx_sh;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] tx_shifted;
    logic [WIDTH-1:0] tx_head;
    logic             word_done, load;
    logic             skip, und_pend;
    logic             rx_full, rx_empty, rx_pop;
    logic             tx_full, tx_empty, tx_pop;

    // pin synchronisers, third stage on SCK/nCS for edge detection
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            {sck_s1, sck_s2, sck_s3} <= {3{CPOL}};
            {ncs_s1, ncs_s2, ncs_s3} <= 3'b111;
            {mosi_s1, mosi_s2}       <= 2'b00;
        end else begin
            {sck_s1, sck_s2, sck_s3} <= {SCK, sck_s1, sck_s2};
            {ncs_s1, ncs_s2, ncs_s3} <= {nCS, ncs_s1, ncs_s2};
            {mosi_s1, mosi_s2}       <= {MOSI, mosi_s1};
        end
    end

    assign lead      = !ncs_s2 && (sck_s3 == CPOL) && (sck_s2 != CPOL);
    assign trail     = !ncs_s2 && (sck_s3 != CPOL) && (sck_s2 == CPOL);
    assign samp      = CPHA ? trail : lead;
    assign shft      = CPHA ? lead : trail;
    assign ncs_fall  = ncs_s3 && !ncs_s2;
    assign ncs_rise  = !ncs_s3 && ncs_s2;
    assign word_done = samp && (count == CW'(WIDTH - 1));
    assign load      = ncs_fall || word_done;

    assign rx_next = MSB_FIRST ? {rx_sh, mosi_s2} : {mosi_s2, rx_sh};
    assign rx_pop  = rx_ready && !rx_empty;
    assign tx_pop  = load && !tx_empty;

    assign tx_shifted = MSB_FIRST ? {tx_sh[WIDTH-2:0], 1'b1}
                                  : {1'b1, tx_sh[WIDTH-1:1]};

    assign MISO     = MSB_FIRST ? tx_sh[WIDTH-1] : tx_sh[0];
    assign MISO_OE  = !ncs_s2;
    assign rx_valid = !rx_empty;
    assign tx_ready = !tx_full;

    // bit counter and receive shifter; a frame edge drops any partial word
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count <= '0;
            rx_sh <= '0;
        end else if (ncs_rise || ncs_fall) begin
            count <= '0;
        end else if (samp) begin
            rx_sh <= MSB_FIRST ? rx_next[WIDTH-2:0] : rx_next[WIDTH-1:1];
            count <= word_done ? '0 : count + CW'(1);
        end
    end

    // transmit shifter: load at word boundary, else shift on shift edges.
    // The shift edge right after a load is skipped so the freshly loaded
    // first bit stays on MISO until the master samples it. An empty-FIFO
    // load only flags underrun once that word actually starts.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            tx_sh    <= '1;
            skip     <= 1'b0;
            und_pend <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (samp && count == '0 && und_pend) begin
                underrun <= 1'b1;
                und_pend <= 1'b0;
            end
            if (load) begin
                tx_sh    <= tx_empty ? '1 : tx_head;
                und_pend <= tx_empty;
                skip     <= CPHA || word_done;
            end else if (shft) begin
                if (skip) skip <= 1'b0;
                else tx_sh <= tx_shifted;
            end
        end
    end

    // word dropped when RX is full and not draining this cycle
    always_ff @(posedge CLK) begin
        if (!nRST) overrun <= 1'b0;
        else overrun <= word_done && rx_full && !rx_ready;
    end

    spi_slave_fifo_buf #(.W(WIDTH), .DEPTH(DEPTH)) u_rx (
        .clk   (CLK),
        .rst_n (nRST),
        .push  (word_done),
        .wdata (rx_next),
        .pop   (rx_pop),
        .rdata (rx_data),
        .empty (rx_empty),
        .full  (rx_full)
    );

    spi_slave_fifo_buf #(.W(WIDTH), .DEPTH(DEPTH)) u_tx (
        .clk   (CLK),
        .rst_n (nRST),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );
endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb_spi_slave_fifo: two instances (mode 0 / 8-bit MSB-first and
// mode 3 / 16-bit LSB-first) driven by a bit-level SPI master.

module tb_spi_slave_fifo;
    localparam int H = 6;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sck, ncs, mosi, miso, oe;
    logic [1:0]  rxv, rxr, txv, txr, ovr, und;
    logic [7:0]  rxd0, txd0;
    logic [15:0] rxd3, txd3;

    int checks = 0;
    int passes = 0;
    int und_hi [2];
    int und_rise [2];
    int ovr_hi [2];
    logic [1:0] und_q = 2'b00;

    logic [31:0] m_tx [2][$];
    logic [31:0] m_rx [2][$];
    int m_und [2];
    int m_ovr [2];
    logic [31:0] fw [$];
    logic [31:0] gw [$];

    typedef struct {
        logic       push;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_rx;
        logic [7:0] exp_mi;
        int         exp_und;
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    spi_slave_fifo u0 (
        .CLK(clk), .nRST(rst_n), .SCK(sck[0]), .nCS(ncs[0]),
        .MOSI(mosi[0]), .MISO(miso[0]), .MISO_OE(oe[0]),
        .rx_data(rxd0), .rx_valid(rxv[0]), .rx_ready(rxr[0]),
        .tx_data(txd0), .tx_valid(txv[0]), .tx_ready(txr[0]),
        .overrun(ovr[0]), .underrun(und[0])
    );

    spi_slave_fifo #(
        .WIDTH(16), .DEPTH(4), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)
    ) u3 (
        .CLK(clk), .nRST(rst_n), .SCK(sck[1]), .nCS(ncs[1]),
        .MOSI(mosi[1]), .MISO(miso[1]), .MISO_OE(oe[1]),
        .rx_data(rxd3), .rx_valid(rxv[1]), .rx_ready(rxr[1]),
        .tx_data(txd3), .tx_valid(txv[1]), .tx_ready(txr[1]),
        .overrun(ovr[1]), .underrun(und[1])
    );

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (und[d]) und_hi[d]++;
            if (und[d] && !und_q[d]) und_rise[d]++;
            if (ovr[d]) ovr_hi[d]++;
        end
        und_q = und;
    end

    function automatic int wd(input int d);
        return (d == 1) ? 16 : 8;
    endfunction

    function automatic logic [31:0] mk(input int d);
        return (32'h1 << wd(d)) - 32'h1;
    endfunction

    function automatic logic [31:0] getrx(input int d);
        return (d == 1) ? {16'h0, rxd3} : {24'h0, rxd0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic xfer(input int d, input logic [31:0] wout,
                        input int nbits, output logic [31:0] win);
        logic pol;
        int   b;
        pol = (d == 1);
        win = '0;
        for (int i = 0; i < nbits; i++) begin
            b = (d == 1) ? i : wd(d) - 1 - i;
            if (d == 0) begin
                mosi[d] = wout[b];
                cyc(H);
                sck[d] = !pol;
                win[b] = miso[d];
                cyc(H);
                sck[d] = pol;
            end else begin
                sck[d] = !pol;
                mosi[d] = wout[b];
                cyc(H);
                sck[d] = pol;
                win[b] = miso[d];
                cyc(H);
            end
        end
    endtask

    task automatic model_load(input int d, output logic [31:0] w);
        if (m_tx[d].size() > 0) begin
            w = m_tx[d].pop_front();
        end else begin
            w = mk(d);
            m_und[d]++;
        end
    endtask

    task automatic frame(input int d, input int nfull, input int ab);
        logic [31:0] got;
        logic [31:0] expw;
        int nw;
        nw = nfull + ((ab > 0) ? 1 : 0);
        gw.delete();
        ncs[d] = 1'b0;
        cyc(8);
        chk("miso_oe in frame", {31'h0, oe[d]}, 32'h1);
        for (int k = 0; k < nw; k++) begin
            model_load(d, expw);
            xfer(d, fw[k], (k < nfull) ? wd(d) : ab, got);
            if (k < nfull) begin
                gw.push_back(got);
                chk("miso word", got, expw);
                if (m_rx[d].size() < D) m_rx[d].push_back(fw[k] & mk(d));
                else m_ovr[d]++;
            end
        end
        if (ab == 0 && m_tx[d].size() > 0) void'(m_tx[d].pop_front());
        cyc(6);
        ncs[d] = 1'b1;
        cyc(8);
        chk("miso_oe idle", {31'h0, oe[d]}, 32'h0);
        chk("underrun pulses", und_rise[d], m_und[d]);
        chk("underrun width", und_hi[d], m_und[d]);
        chk("overrun pulses", ovr_hi[d], m_ovr[d]);
    endtask

    task automatic push(input int d, input logic [31:0] w);
        chk("tx_ready", {31'h0, txr[d]}, {31'h0, m_tx[d].size() < D});
        if (m_tx[d].size() < D) begin
            if (d == 1) txd3 = w[15:0];
            else txd0 = w[7:0];
            txv[d] = 1'b1;
            cyc(1);
            txv[d] = 1'b0;
            m_tx[d].push_back(w & mk(d));
        end
    endtask

    task automatic drain(input int d);
        while (m_rx[d].size() > 0) begin
            chk("rx_valid", {31'h0, rxv[d]}, 32'h1);
            chk("rx_data", getrx(d), m_rx[d].pop_front());
            rxr[d] = 1'b1;
            cyc(1);
            rxr[d] = 1'b0;
        end
        chk("rx empty", {31'h0, rxv[d]}, 32'h0);
    endtask

    task automatic reset_checks(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk({nm, " miso"}, {31'h0, miso[d]}, 32'h1);
            chk({nm, " miso_oe"}, {31'h0, oe[d]}, 32'h0);
            chk({nm, " rx_valid"}, {31'h0, rxv[d]}, 32'h0);
            chk({nm, " tx_ready"}, {31'h0, txr[d]}, 32'h1);
            chk({nm, " overrun"}, {31'h0, ovr[d]}, 32'h0);
            chk({nm, " underrun"}, {31'h0, und[d]}, 32'h0);
            chk({nm, " rx_data"}, getrx(d), 32'h0);
        end
    endtask

    initial begin
        int u_b, o_b, d, np, nf, ab;
        logic [31:0] g;

        tbl[0] = '{1'b1, 8'h3C, 8'hA5, 8'hA5, 8'h3C, 0};
        tbl[1] = '{1'b0, 8'h00, 8'h5A, 8'h5A, 8'hFF, 1};
        tbl[2] = '{1'b1, 8'h81, 8'h00, 8'h00, 8'h81, 0};
        tbl[3] = '{1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00, 0};
        tbl[4] = '{1'b1, 8'h6E, 8'h01, 8'h01, 8'h6E, 0};

        rst_n = 1'b0;
        sck = 2'b10;
        ncs = 2'b11;
        mosi = 2'b00;
        rxr = 2'b00;
        txv = 2'b00;
        txd0 = '0;
        txd3 = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        reset_checks("reset");

        for (int i = 0; i < 5; i++) begin
            u_b = und_rise[0];
            o_b = ovr_hi[0];
            if (tbl[i].push) push(0, {24'h0, tbl[i].tx});
            fw.delete();
            fw.push_back({24'h0, tbl[i].mo});
            frame(0, 1, 0);
            chk("tbl miso", gw[0], {24'h0, tbl[i].exp_mi});
            chk("tbl rx_valid", {31'h0, rxv[0]}, 32'h1);
            chk("tbl rx_data", {24'h0, rxd0}, {24'h0, tbl[i].exp_rx});
            chk("tbl underrun", und_rise[0] - u_b, tbl[i].exp_und);
            chk("tbl overrun", ovr_hi[0] - o_b, 0);
            drain(0);
        end

        o_b = ovr_hi[0];
        fw.delete();
        for (int k = 1; k <= 5; k++) fw.push_back(k);
        frame(0, 5, 0);
        chk("ovr count", ovr_hi[0] - o_b, 1);
        chk("ovr head", {24'h0, rxd0}, 32'h01);
        chk("ovr tx_ready", {31'h0, txr[0]}, 32'h1);
        drain(0);

        fw.delete();
        fw.push_back(32'hFF);
        frame(0, 0, 3);
        chk("abort rx_valid", {31'h0, rxv[0]}, 32'h0);
        fw.delete();
        fw.push_back(32'h5A);
        frame(0, 1, 0);
        chk("abort then word", {24'h0, rxd0}, 32'h5A);
        drain(0);

        push(1, 32'h1234);
        push(1, 32'hBEEF);
        fw.delete();
        fw.push_back(32'h00FF);
        fw.push_back(32'h8001);
        frame(1, 2, 0);
        chk("mode3 miso0", gw[0], 32'h1234);
        chk("mode3 miso1", gw[1], 32'hBEEF);
        chk("mode3 rx head", {16'h0, rxd3}, 32'h00FF);
        drain(1);

        fw.delete();
        fw.push_back(32'h11);
        fw.push_back(32'h22);
        frame(0, 2, 0);
        push(0, 32'hA7);
        ncs[0] = 1'b0;
        cyc(8);
        model_load(0, g);
        xfer(0, 32'h96, 3, g);
        rst_n = 1'b0;
        cyc(1);
        chk("rst rx_valid", {31'h0, rxv[0]}, 32'h0);
        chk("rst tx_ready", {31'h0, txr[0]}, 32'h1);
        chk("rst miso", {31'h0, miso[0]}, 32'h1);
        chk("rst miso_oe", {31'h0, oe[0]}, 32'h0);
        rst_n = 1'b1;
        ncs[0] = 1'b1;
        mosi[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_tx[i].delete();
            m_rx[i].delete();
        end
        cyc(4);
        reset_checks("post-reset");
        push(0, 32'hC3);
        fw.delete();
        fw.push_back(32'h5A);
        frame(0, 1, 0);
        chk("rst next miso", gw[0], 32'hC3);
        chk("rst next rx", {24'h0, rxd0}, 32'h5A);
        drain(0);

        for (int it = 0; it < 24; it++) begin
            d = $urandom_range(0, 1);
            np = $urandom_range(0, 3);
            nf = $urandom_range(1, 3);
            ab = 0;
            if ($urandom_range(0, 4) == 0) ab = $urandom_range(1, wd(d) - 1);
            for (int p = 0; p < np; p++) push(d, $urandom);
            fw.delete();
            for (int k = 0; k <= nf; k++) fw.push_back($urandom & mk(d));
            frame(d, nf, ab);
            if ($urandom_range(0, 1) == 1) drain(d);
        end
        drain(0);
        drain(1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/spi_slave_fifo.md
# spi_slave_fifo

Parametrised SPI slave for the AVR co-simulation benches. It is a successor to the fixed-mode, byte-only slave attached to the ATmega8 port-B SPI pins. The block oversamples SCK/nCS/MOSI on the system clock and supports all four CPOL/CPHA modes, a configurable word width and bit order. Received and transmitted words are buffered in independent FIFOs with valid/ready handshakes, so the bench or downstream logic can stream multi-word transfers without per-bit timing.

## Interface
Parameters:
- WIDTH, 8, bits per SPI word (2..32)
- DEPTH, 4, entries per FIFO (power of two, ≥2)
- CPOL, 0, SCK idle level
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first

Ports (one clock; reset is synchronous and active-low):
- CLK  in  1  system clock, all logic on rising edge
- nRST  in  1  synchronous active-low reset
- SCK  in  1  SPI clock from master, asynchronous
- nCS  in  1  active-low chip select, asynchronous
- MOSI  in  1  master-out data
- MISO  out  1  slave-out data
- MISO_OE  out  1  MISO drive enable (external tri-state)
- rx_data  out  WIDTH  head of RX FIFO
- rx_valid  out  1  RX FIFO non-empty
- rx_ready  in  1  pop RX head when rx_valid & rx_ready
- tx_data  in  WIDTH  word to queue for transmit
- tx_valid  in  1  push request
- tx_ready  out  1  TX FIFO not full
- overrun  out  1  one-cycle pulse: received word dropped, RX full
- underrun  out  1  one-cycle pulse: word started with TX FIFO empty

## Operation
- SCK, nCS and MOSI each pass through a 2-flop synchroniser. A third register on SCK and nCS drives edge detection.
- Leading edge = SCK transition away from CPOL. Trailing edge = return to CPOL.
- Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other edge.
- Edges are ignored while synchronised nCS is high.
- Bit counter runs 0..WIDTH-1. On each sample edge, the synchronised MOSI enters the RX shift register (at LSB if MSB_FIRST, else at MSB).
- On the sample edge with count = WIDTH-1:
  - the assembled word is pushed to the RX FIFO;
  - if the FIFO is full and not popped in the same cycle, the word is dropped and overrun pulses;
  - the counter returns to 0;
  - a word boundary is raised.
- TX load at word boundary, i.e. the nCS falling edge or word completion. Pop the TX head into the TX shift register.
  - If TX is empty, load all-ones and pulse underrun.
  - A transmitted word is consumed at load, even if the transfer is later aborted.
- MISO = TX shift register bit (MSB if MSB_FIRST, else LSB).
  - The register shifts on shift edges, except on the first leading edge of a word when CPHA=1 (the bit is already presented).
  - A boundary load in the same cycle overrides the shift.
- nCS rising edge mid-word: discard the partial RX word (no push), clear the counter, no overrun or underrun.
- MISO_OE = NOT synchronised nCS. MISO holds its last value when OE is low.
- FIFOs are first-word-fall-through.
  - Push and pop in the same cycle on a full FIFO both succeed.
  - tx_ready = not full; rx_valid = not empty.
  - Occupancy never exceeds DEPTH.

## Timing
- Reset values:
  - MISO = 1, MISO_OE = 0, rx_valid = 0, tx_ready = 1, overrun = 0, underrun = 0, rx_data = 0;
  - both FIFOs empty, counter 0, synchronisers = idle (SCK = CPOL, nCS = 1).
- nRST low mid-transfer aborts immediately: no push, FIFOs flushed, same state as power-up reset.
- Pin-edge to detected-edge latency: 3 CLK.
- rx_valid rises 1 CLK after the final sample edge is detected, if the RX FIFO was empty.
- MISO changes 1 CLK after a detected shift edge or boundary, i.e. ≤4 CLK after the pin edge.
- tx_ready rises 1 CLK after a TX pop from a full FIFO.
- Input requirements:
  - SCK high and low phases each ≥4 CLK;
  - nCS falling to first SCK edge ≥5 CLK;
  - last SCK edge to nCS rising ≥4 CLK.
- Violation of the input requirements is undefined (bench checks, RTL does not).

## Test plan
- Mode 0, WIDTH=8, tx queue 0x3C, master sends 0xA5 → rx_data=0xA5, rx_valid=1, master reads 0x3C, no pulses.
- Mode 3, MSB_FIRST=0, WIDTH=16, tx 0x1234 then 0xBEEF, master sends 0x00FF, 0x8001 in one nCS frame → RX 0x00FF, 0x8001 in order, master reads 0x1234, 0xBEEF.
- Empty TX FIFO, one word → master reads 0xFF, underrun pulses once for exactly 1 CLK.
- DEPTH=4, rx_ready=0, five words 0x01..0x05 → RX holds 0x01..0x04, overrun pulses on word 5, tx_ready unaffected.
- nCS raised after 3 bits, then a full frame sending 0x5A → only 0x5A in RX, counter restarts at 0, MISO_OE low between frames.
- nRST low 1 CLK mid-word with 2 RX words pending → rx_valid=0, tx_ready=1, MISO=1, MISO_OE=0 next cycle; the next frame receives correctly.
